mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO for the single-cycle MIPS core.
- Operands come from the register file read ports (ReadData1 → a, ReadData2 → b).
- hi/lo feed the writeback mux, so MFHI/MFLO results reach register file WriteData.
- The core stalls on busy.

---
 rtl/mult_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative radix-2 multiply/divide unit with architectural HI/LO.
//            Optional macro MDU_DIVZERO_FLAG_EN adds the div_zero output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
   ,output logic             div_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST = 6'(WIDTH - 1);

    state_t r_state, w_nextState;

    logic [5:0]       r_count;
    logic [WIDTH-1:0] r_hiAcc;
    logic [WIDTH-1:0] r_loAcc;
    logic [WIDTH-1:0] r_opnd;
    logic             r_isDiv;
    logic             r_negMain;
    logic             r_negRem;
    logic             r_divZero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dzPulse;

    // Operand magnitudes and signs captured at launch
    logic             w_signed;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

    assign w_signed = ~op[0];
    assign w_aNeg   = w_signed & a[WIDTH-1];
    assign w_bNeg   = w_signed & b[WIDTH-1];
    assign w_absA   = w_aNeg ? -a : a;
    assign w_absB   = w_bNeg ? -b : b;

    // Multiply step: conditional add, then shift {acc, multiplier} right
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    assign w_addend = r_loAcc[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_hiAcc} + {1'b0, w_addend};

    // Restoring divide step: shift {rem, dividend} left, trial subtract
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    assign w_remShift = {r_hiAcc, r_loAcc[WIDTH-1]};
    assign w_ge       = (w_remShift >= {1'b0, r_opnd});
    assign w_diff     = w_remShift - {1'b0, r_opnd};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;

    assign w_prod    = {r_hiAcc, r_loAcc};
    assign w_prodFix = r_negMain ? -w_prod : w_prod;
    assign w_quoFix  = r_divZero ? '1 : (r_negMain ? -r_loAcc : r_loAcc);
    // With a zero divisor the remainder path reproduces |a|, so the sign fix returns a
    assign w_remFix  = r_negRem ? -r_hiAcc : r_hiAcc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (r_count == c_LAST) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_hiAcc   <= '0;
            r_loAcc   <= '0;
            r_opnd    <= '0;
            r_isDiv   <= 1'b0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dzPulse <= 1'b0;
        end else begin
            r_done    <= (r_state == FIX);
            r_dzPulse <= (r_state == FIX) & r_divZero;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (start) begin
                        r_hiAcc   <= '0;
                        r_loAcc   <= op[1] ? w_absA : w_absB;
                        r_opnd    <= op[1] ? w_absB : w_absA;
                        r_isDiv   <= op[1];
                        r_negMain <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_divZero <= op[1] & (b == '0);
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                RUN: begin
                    r_count <= r_count + 6'd1;
                    if (r_isDiv) begin
                        r_hiAcc <= w_ge ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
                        r_loAcc <= {r_loAcc[WIDTH-2:0], w_ge};
                    end else begin
                        r_hiAcc <= w_sum[WIDTH:1];
                        r_loAcc <= {w_sum[0], r_loAcc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    r_count <= '0;
                    if (r_isDiv) begin
                        r_hi <= w_remFix;
                        r_lo <= w_quoFix;
                    end else begin
                        r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prodFix[WIDTH-1:0];
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

`ifdef MDU_DIVZERO_FLAG_EN
    assign div_zero = r_dzPulse;
`else
    logic w_unusedDz;
    assign w_unusedDz = r_dzPulse;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic         div_zero;
`endif

    int nTotal = 0;
    int nBad   = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MDU_DIVZERO_FLAG_EN
       ,.div_zero(div_zero)
`endif
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTotal++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a launch so that the next posedge is E0; returns at the negedge after E0
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkVal("busy_after_E0", 64'(busy), 64'd1);
    endtask

    // Waits for done (bounded), checks latency, busy window, results and pulse width.
    // inject=1 pulses start(DIVU)+lo_we mid-operation to show both are ignored.
    task automatic waitDone(input string tag, input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                            input logic expDz, input logic inject);
        int doneAt  = 0;
        int busyErr = 0;
        logic [W-1:0] loBefore;
        loBefore = lo;
        for (int k = 1; k <= 40; k++) begin
            if (inject && k == 5) begin
                start = 1'b1;
                op    = 2'b11;
                a     = 32'd100;
                b     = 32'd7;
                lo_we = 1'b1;
                wdata = 32'h5555AAAA;
            end
            @(posedge clk);
            @(negedge clk);
            if (inject && k == 5) begin
                start = 1'b0;
                lo_we = 1'b0;
                checkVal({tag, "_lo_we_ignored"}, 64'(lo), 64'(loBefore));
            end
            if (done) begin
                doneAt = k;
                if (busy) busyErr++;
`ifdef MDU_DIVZERO_FLAG_EN
                checkVal({tag, "_div_zero"}, 64'(div_zero), 64'(expDz));
`endif
                break;
            end
            if (!busy) busyErr++;
        end
        checkVal({tag, "_latency"}, 64'(doneAt), 64'(W + 1));
        checkVal({tag, "_busy_window"}, 64'(busyErr), 64'd0);
        checkVal({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkVal({tag, "_lo"}, 64'(lo), 64'(expLo));
        @(negedge clk);
        checkVal({tag, "_done_pulse"}, 64'(done), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        checkVal({tag, "_div_zero_clear"}, 64'(div_zero), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        @(negedge clk);
        @(negedge clk);
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_done", 64'(done), 64'd0);
        checkVal("rst_hi", 64'(hi), 64'd0);
        checkVal("rst_lo", 64'(lo), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        checkVal("rst_div_zero", 64'(div_zero), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);

        launch(2'b00, 32'hFFFFFFFD, 32'd5);
        waitDone("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        launch(2'b11, 32'd100, 32'd7);
        waitDone("divu", 32'h00000002, 32'h0000000E, 1'b0, 1'b0);

        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        waitDone("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        waitDone("div_ovf", 32'h00000000, 32'h80000000, 1'b0, 1'b0);

        launch(2'b10, 32'h00001234, 32'd0);
        waitDone("div_zero", 32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b0);
        launch(2'b11, 32'hFFFFFFF0, 32'd0);
        waitDone("divu_zero", 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1'b0);

        hi_we = 1'b1;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        checkVal("mthi", 64'(hi), 64'h00000000CAFEF00D);
        checkVal("mthi_lo_kept", 64'(lo), 64'h00000000FFFFFFFF);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkVal("mt_both_hi", 64'(hi), 64'h0000000012345678);
        checkVal("mt_both_lo", 64'(lo), 64'h0000000012345678);

        launch(2'b00, 32'd3, 32'd4);
        waitDone("mult_hazard", 32'h00000000, 32'h0000000C, 1'b0, 1'b1);

        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        launch(2'b01, 32'd2, 32'd3);
        hi_we = 1'b0;
        checkVal("start_beats_mthi", 64'(hi), 64'd0);
        waitDone("multu_small", 32'h00000000, 32'h00000006, 1'b0, 1'b0);

        hi_we = 1'b1;
        wdata = 32'h00001111;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        launch(2'b01, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("abort_busy", 64'(busy), 64'd0);
        checkVal("abort_done", 64'(done), 64'd0);
        checkVal("abort_hi", 64'(hi), 64'd0);
        checkVal("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkVal("abort_no_done", 64'(dones), 64'd0);
        launch(2'b01, 32'd7, 32'd9);
        waitDone("multu_after_rst", 32'h00000000, 32'h0000003F, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule

`default_nettype wire
